// File: rtl/rand_roller_hist.sv
// Dice-roller core: a Galois LFSR feeds a slowing roll sequence, and each final result
// is pushed into a history buffer. The buffer can be browsed while idle.
module rand_roller_hist #(
    parameter int              W      = 4,
    parameter int              DEPTH  = 8,
    parameter int              LW     = 16,
    parameter logic [LW-1:0]   TAPS   = 16'hB400,
    parameter logic [LW-1:0]   SEED   = 1,
    parameter int              T      = 6250000,
    parameter int              NPHASE = 3,
    parameter int              DCLICK = 12500000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic                     i_next,
    input  logic                     i_seed_load,
    input  logic [LW-1:0]            i_seed,
    output logic [W-1:0]             o_value,
    output logic [$clog2(DEPTH)-1:0] o_idx,
    output logic [2**W-1:0]          o_value_oh,
    output logic [DEPTH-1:0]         o_idx_oh,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_fill
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(4*T);
    localparam int PW = (NPHASE > 1) ? $clog2(NPHASE) : 1;
    localparam int TW = $clog2(DCLICK + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(4*T - 1);
    localparam logic [CW-1:0] PER0_LAST = CW'(T - 1);
    localparam logic [CW-1:0] PER1_LAST = CW'(2*T - 1);

    typedef enum logic {IDLE, ROLL} state_t;

    state_t                     state_q, state_d;
    logic [LW-1:0]              lfsr;
    logic [W-1:0]               number, num_d;
    logic [DEPTH-1:0][W-1:0]    hist;
    logic [IW-1:0]              idx, idx_step;
    logic [IW:0]                fill;
    logic [PW-1:0]              p;
    logic [CW-1:0]              cnt, sub, per_last;
    logic                       armed;
    logic [TW-1:0]              timer;
    logic                       upd, commit, phase_end;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            lfsr <= SEED;
        else if (i_seed_load)
            lfsr <= (i_seed == '0) ? LW'(1) : i_seed;
        else
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    end

    // Update period is T<<p; from phase 2 on it reaches 4T, so only cnt=0 updates.
    always_comb begin
        state_d   = state_q;
        upd       = 1'b0;
        commit    = 1'b0;
        phase_end = 1'b0;
        per_last  = (p == PW'(0)) ? PER0_LAST : (p == PW'(1)) ? PER1_LAST : CNT_LAST;
        case (state_q)
            IDLE: if (i_start) state_d = ROLL;
            ROLL: begin
                upd       = (sub == '0) && !i_stop;
                phase_end = (cnt == CNT_LAST);
                if (i_stop || (phase_end && p == PW'(NPHASE - 1))) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        num_d = upd ? lfsr[W-1:0] : number;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            p      <= '0;
            cnt    <= '0;
            sub    <= '0;
            number <= '0;
            hist   <= '0;
            fill   <= '0;
        end else begin
            number <= num_d;
            if (state_q == IDLE) begin
                p   <= '0;
                cnt <= '0;
                sub <= '0;
            end else if (phase_end) begin
                p   <= p + PW'(1);
                cnt <= '0;
                sub <= '0;
            end else begin
                cnt <= cnt + CW'(1);
                sub <= (sub == per_last) ? '0 : sub + CW'(1);
            end
            if (commit) begin
                hist <= {hist[DEPTH-2:0], num_d};
                if (fill != (IW+1)'(DEPTH))
                    fill <= fill + (IW+1)'(1);
            end
        end
    end

    assign idx_step = (({1'b0, idx} + (IW+1)'(1)) >= fill) ? '0 : idx + IW'(1);

    // A second press inside the window returns home; otherwise each press steps and re-arms.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx   <= '0;
            armed <= 1'b0;
            timer <= '0;
        end else if (state_q == ROLL || i_start) begin
            idx   <= '0;
            armed <= 1'b0;
            timer <= '0;
        end else if (i_next) begin
            if (armed && timer < TW'(DCLICK)) begin
                idx   <= '0;
                armed <= 1'b0;
            end else begin
                idx   <= idx_step;
                armed <= 1'b1;
                timer <= '0;
            end
        end else if (armed) begin
            if (timer >= TW'(DCLICK))
                armed <= 1'b0;
            else
                timer <= timer + TW'(1);
        end
    end

    assign o_value    = (idx == '0) ? number : hist[idx];
    assign o_idx      = idx;
    assign o_value_oh = {{(2**W-1){1'b0}}, 1'b1} << o_value;
    assign o_idx_oh   = {{(DEPTH-1){1'b0}}, 1'b1} << idx;
    assign o_busy     = (state_q == ROLL);
    assign o_fill     = fill;

endmodule

// File: tb/tb_rand_roller_hist.sv
// Directed bench for rand_roller_hist (W=4, DEPTH=4, T=2, NPHASE=3, DCLICK=5).
module tb_rand_roller_hist;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, nxt, seed_load;
    logic [15:0] seed;
    logic [3:0]  value;
    logic [1:0]  idx;
    logic [15:0] value_oh;
    logic [3:0]  idx_oh;
    logic        busy;
    logic [2:0]  fill;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_lfsr;
    logic [3:0]  exp_num;
    logic [3:0]  r [0:4];
    logic [15:0] pre_s;

    always #5 clk = ~clk;

    rand_roller_hist #(
        .W(4), .DEPTH(4), .LW(16), .TAPS(16'hB400), .SEED(16'd1),
        .T(2), .NPHASE(3), .DCLICK(5)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_next(nxt),
        .i_seed_load(seed_load), .i_seed(seed), .o_value(value), .o_idx(idx),
        .o_value_oh(value_oh), .o_idx_oh(idx_oh), .o_busy(busy), .o_fill(fill)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock edge; the LFSR reference advances alongside the DUT.
    task automatic tick();
        logic [15:0] pre;
        logic        ld, rs;
        logic [15:0] sd;
        pre = m_lfsr; ld = seed_load; sd = seed; rs = rst_n;
        @(posedge clk);
        if (!rs)        m_lfsr = 16'd1;
        else if (ld)    m_lfsr = (sd == 16'd0) ? 16'd1 : sd;
        else            m_lfsr = (pre >> 1) ^ (pre[0] ? 16'hB400 : 16'h0000);
        #1;
    endtask

    function automatic bit upd_cycle(input int i);
        return i inside {0, 2, 4, 6, 8, 12, 16};
    endfunction

    task automatic view(input string tag, input logic [1:0] ei, input logic [3:0] ev);
        chk({tag, "_idx"}, 32'(idx), 32'(ei));
        chk({tag, "_val"}, 32'(value), 32'(ev));
        chk({tag, "_idxoh"}, 32'(idx_oh), 32'(4'b0001 << ei));
        chk({tag, "_valoh"}, 32'(value_oh), 32'(16'h0001 << ev));
    endtask

    task automatic pulse_next();
        nxt = 1'b1; tick(); nxt = 1'b0;
    endtask

    // Runs one roll; stop_at < 0 means let it finish on its own.
    task automatic roll(input int stop_at, output logic [3:0] res);
        logic [15:0] pre;
        start = 1'b1; tick(); start = 1'b0;
        chk("roll_busy_rise", 32'(busy), 32'd1);
        for (int i = 0; i < 24; i++) begin
            pre = m_lfsr;
            if (i == stop_at) stop = 1'b1;
            tick();
            stop = 1'b0;
            if (upd_cycle(i)) exp_num = pre[3:0];
            chk("roll_num", 32'(value), 32'(exp_num));
            if (i == stop_at) break;
            if (i < 23) chk("roll_busy", 32'(busy), 32'd1);
        end
        chk("roll_busy_fall", 32'(busy), 32'd0);
        chk("roll_valoh", 32'(value_oh), 32'(16'h0001 << exp_num));
        res = exp_num;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; nxt = 1'b0; seed_load = 1'b0; seed = 16'h0;
        m_lfsr = 16'd1; exp_num = 4'd0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        view("rst", 2'd0, 4'd0);
        rst_n = 1'b1;

        seed_load = 1'b1; seed = 16'h0000; tick(); seed_load = 1'b0;
        repeat (100) tick();

        roll(-1, r[0]);
        chk("full_fill", 32'(fill), 32'd1);
        roll(5, r[1]);
        chk("stop5_fill", 32'(fill), 32'd2);
        roll(23, r[2]);
        chk("stop_end_fill", 32'(fill), 32'd3);

        // hist = {r2, r1, r0}, fill = 3
        pulse_next(); view("b1", 2'd1, r[1]); repeat (9) tick();
        pulse_next(); view("b2", 2'd2, r[0]); repeat (9) tick();
        pulse_next(); view("b3", 2'd0, r[2]); repeat (9) tick();

        pulse_next(); view("dc_a", 2'd1, r[1]); repeat (2) tick();
        pulse_next(); view("dc_b", 2'd0, r[2]); repeat (10) tick();

        pulse_next(); view("sc_a", 2'd1, r[1]); repeat (5) tick();
        pulse_next(); view("sc_b", 2'd2, r[0]); repeat (10) tick();

        pre_s = m_lfsr;
        start = 1'b1; nxt = 1'b1; tick(); start = 1'b0; nxt = 1'b0;
        chk("sn_busy", 32'(busy), 32'd1);
        chk("sn_idx", 32'(idx), 32'd0);
        pre_s = m_lfsr;
        nxt = 1'b1; tick(); nxt = 1'b0;
        exp_num = pre_s[3:0];
        chk("roll_next_idx", 32'(idx), 32'd0);
        chk("roll_next_val", 32'(value), 32'(exp_num));
        stop = 1'b1; tick(); stop = 1'b0;
        chk("sn_stop_busy", 32'(busy), 32'd0);
        chk("sn_stop_fill", 32'(fill), 32'd4);
        chk("sn_stop_val", 32'(value), 32'(exp_num));

        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0; m_lfsr = 16'd1; exp_num = 4'd0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fill", 32'(fill), 32'd0);
        view("mid_rst", 2'd0, 4'd0);
        tick();
        rst_n = 1'b1;

        roll(-1, r[0]); chk("sat_fill1", 32'(fill), 32'd1);
        roll(-1, r[1]); chk("sat_fill2", 32'(fill), 32'd2);
        roll(-1, r[2]); chk("sat_fill3", 32'(fill), 32'd3);
        roll(-1, r[3]); chk("sat_fill4", 32'(fill), 32'd4);
        roll(-1, r[4]); chk("sat_fill5", 32'(fill), 32'd4);
        repeat (2) tick();
        pulse_next(); view("h1", 2'd1, r[3]); repeat (9) tick();
        pulse_next(); view("h2", 2'd2, r[2]); repeat (9) tick();
        pulse_next(); view("h3", 2'd3, r[1]); repeat (9) tick();
        pulse_next(); view("h0", 2'd0, r[4]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
